// File: rtl/viterbi_pkg.sv
// Convolutional code definitions shared by the encoder framer and the Viterbi decoder.
// The generators here must match the decoder's branch-metric tables.
package viterbi_pkg;

  localparam int K = 4;
  localparam logic [K-1:0] G0_DEF = 4'b1101;
  localparam logic [K-1:0] G1_DEF = 4'b1111;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DATA = 2'd1,
    TAIL = 2'd2,
    GAP  = 2'd3
  } enc_state_t;

  // vec = {u, s[2], s[1], s[0]}; returns the coded pair {c0, c1}.
  function automatic logic [1:0] enc_symbol(input logic [K-1:0] vec,
                                            input logic [K-1:0] g0,
                                            input logic [K-1:0] g1);
    return {^(vec & g0), ^(vec & g1)};
  endfunction

endpackage

// File: rtl/conv_enc_core.sv
// Rate-1/2 encoder kernel: combinational symbol from {u, s} plus the state register.
// clr forces s to zero for the current symbol, so a frame's first bit sees a clean trellis.
module conv_enc_core
  import viterbi_pkg::*;
#(
  parameter logic [K-1:0] G0 = G0_DEF,
  parameter logic [K-1:0] G1 = G1_DEF
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       clr,
  input  logic       adv,
  input  logic       u,
  output logic [1:0] c
);

  logic [K-2:0] s_q;
  logic [K-2:0] s_d;
  logic [K-2:0] s_cur;

  always_comb begin
    s_cur = clr ? '0 : s_q;
    c     = enc_symbol({u, s_cur}, G0, G1);
    s_d   = adv ? {u, s_cur[K-2:1]} : s_cur;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) s_q <= '0;
    else      s_q <= s_d;
  end

endmodule

// File: rtl/conv_enc_framer.sv
// Frame-based convolutional encoder feeding the Viterbi decoder: bytes in over valid/ready,
// one coded symbol per cycle out, 3-bit zero tail per frame, then an enable-low gap.
module conv_enc_framer
  import viterbi_pkg::*;
#(
  parameter int          FRAME_BYTES = 16,
  parameter int          GAP_CYCLES  = 2,
  parameter logic [3:0]  G0          = G0_DEF,
  parameter logic [3:0]  G1          = G1_DEF
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       in_valid,
  input  logic [7:0] in_data,
  output logic       in_ready,
  output logic       enc_enable,
  output logic [1:0] enc_d,
  output logic       frame_start,
  output logic       frame_done,
  output logic       underrun,
  input  logic       clr_underrun
);

  localparam int BC_W = $clog2(FRAME_BYTES + 1);
  localparam int GC_W = $clog2(GAP_CYCLES + 1);

  enc_state_t       state_q, state_d;
  logic [7:0]       hold_q, hold_d;
  logic             hold_full_q, hold_full_d;
  logic [7:0]       shreg_q, shreg_d;
  logic [2:0]       bit_cnt_q, bit_cnt_d;
  logic [BC_W-1:0]  byte_cnt_q, byte_cnt_d;
  logic [1:0]       tail_cnt_q, tail_cnt_d;
  logic [GC_W-1:0]  gap_cnt_q, gap_cnt_d;
  logic             enc_en_q, enc_en_d;
  logic [1:0]       enc_d_q, enc_d_d;
  logic             start_q, start_d;
  logic             done_q, done_d;
  logic             underrun_q, underrun_d;

  logic             accept;
  logic             load;
  logic             emit;
  logic             underrun_set;
  logic             core_clr;
  logic             core_u;
  logic [1:0]       core_c;

  assign in_ready = !hold_full_q;
  assign accept   = in_valid && !hold_full_q;

  conv_enc_core #(
    .G0 (G0),
    .G1 (G1)
  ) u_core (
    .clk (clk),
    .rst (rst),
    .clr (core_clr),
    .adv (emit),
    .u   (core_u),
    .c   (core_c)
  );

  always_comb begin
    state_d      = state_q;
    hold_d       = hold_q;
    hold_full_d  = hold_full_q;
    shreg_d      = shreg_q;
    bit_cnt_d    = bit_cnt_q;
    byte_cnt_d   = byte_cnt_q;
    tail_cnt_d   = tail_cnt_q;
    gap_cnt_d    = gap_cnt_q;
    start_d      = 1'b0;
    done_d       = 1'b0;
    underrun_set = 1'b0;
    load         = 1'b0;
    emit         = 1'b0;
    core_clr     = 1'b0;
    core_u       = 1'b0;

    // Accept and consume are mutually exclusive: consume needs hold_full, accept needs it clear.
    if (accept) begin
      hold_d      = in_data;
      hold_full_d = 1'b1;
    end

    case (state_q)
      IDLE: begin
        if (hold_full_q) begin
          load       = 1'b1;
          emit       = 1'b1;
          core_clr   = 1'b1;
          start_d    = 1'b1;
          byte_cnt_d = BC_W'(1);
          state_d    = DATA;
        end
      end
      DATA: begin
        // bit_cnt is the index of the bit already sent; at 7 this edge picks the next source.
        if (bit_cnt_q != 3'd7) begin
          emit      = 1'b1;
          core_u    = shreg_q[7];
          shreg_d   = {shreg_q[6:0], 1'b0};
          bit_cnt_d = bit_cnt_q + 3'd1;
        end else if (byte_cnt_q == BC_W'(FRAME_BYTES)) begin
          emit       = 1'b1;
          tail_cnt_d = 2'd1;
          state_d    = TAIL;
        end else if (hold_full_q) begin
          load       = 1'b1;
          emit       = 1'b1;
          byte_cnt_d = byte_cnt_q + BC_W'(1);
        end else begin
          underrun_set = 1'b1;
          gap_cnt_d    = '0;
          state_d      = GAP;
        end
      end
      TAIL: begin
        emit       = 1'b1;
        tail_cnt_d = tail_cnt_q + 2'd1;
        if (tail_cnt_q == 2'd2) begin
          done_d    = 1'b1;
          gap_cnt_d = '0;
          state_d   = GAP;
        end
      end
      GAP: begin
        gap_cnt_d = gap_cnt_q + GC_W'(1);
        if (gap_cnt_q == GC_W'(GAP_CYCLES - 1)) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // The first bit of a freshly loaded byte goes out on the load edge itself.
    if (load) begin
      hold_full_d = 1'b0;
      shreg_d     = {hold_q[6:0], 1'b0};
      bit_cnt_d   = 3'd0;
      core_u      = hold_q[7];
    end

    underrun_d = underrun_set | (underrun_q & ~clr_underrun);
  end

  always_comb begin
    enc_en_d = emit;
    enc_d_d  = emit ? core_c : 2'b00;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      hold_full_q <= 1'b0;
      bit_cnt_q   <= '0;
      byte_cnt_q  <= '0;
      tail_cnt_q  <= '0;
      gap_cnt_q   <= '0;
      enc_en_q    <= 1'b0;
      enc_d_q     <= 2'b00;
      start_q     <= 1'b0;
      done_q      <= 1'b0;
      underrun_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      hold_full_q <= hold_full_d;
      bit_cnt_q   <= bit_cnt_d;
      byte_cnt_q  <= byte_cnt_d;
      tail_cnt_q  <= tail_cnt_d;
      gap_cnt_q   <= gap_cnt_d;
      enc_en_q    <= enc_en_d;
      enc_d_q     <= enc_d_d;
      start_q     <= start_d;
      done_q      <= done_d;
      underrun_q  <= underrun_d;
    end
  end

  // Byte registers are qualified by hold_full / state and need no reset.
  always_ff @(posedge clk) begin
    hold_q  <= hold_d;
    shreg_q <= shreg_d;
  end

  assign enc_enable  = enc_en_q;
  assign enc_d       = enc_d_q;
  assign frame_start = start_q;
  assign frame_done  = done_q;
  assign underrun    = underrun_q;

endmodule

// File: tb/tb_conv_enc_framer.sv
// Bench for conv_enc_framer: a 1-byte-frame and a 16-byte-frame instance checked against
// a convolution model of each frame's symbol stream plus a hard-decision inverse decoder.
module tb_conv_enc_framer;

  localparam int FB0 = 1;
  localparam int FB1 = 16;

  typedef struct packed {
    logic [1:0] d;
    logic       st;
    logic       dn;
  } sym_t;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       iv   [2];
  logic [7:0] idat [2];
  logic       clr  [2];
  logic       rdy  [2];
  logic       en   [2];
  logic [1:0] d    [2];
  logic       fs   [2];
  logic       fd   [2];
  logic       ur   [2];

  int   checks = 0;
  int   errors = 0;
  sym_t exp_q [2][$];
  logic [7:0] pay [$];
  int   run [2];
  int   low [2];
  int   last_gap [2];
  int   fb [2];
  logic [3:0] g0v;
  logic [3:0] g1v;
  logic [2:0] hist;
  logic dec_on;
  logic dec_q [$];
  sym_t e;
  logic ub;

  conv_enc_framer #(.FRAME_BYTES(FB0), .GAP_CYCLES(2)) dut1 (
    .clk(clk), .rst(rst), .in_valid(iv[0]), .in_data(idat[0]), .in_ready(rdy[0]),
    .enc_enable(en[0]), .enc_d(d[0]), .frame_start(fs[0]), .frame_done(fd[0]),
    .underrun(ur[0]), .clr_underrun(clr[0]));

  conv_enc_framer #(.FRAME_BYTES(FB1), .GAP_CYCLES(2)) dut16 (
    .clk(clk), .rst(rst), .in_valid(iv[1]), .in_data(idat[1]), .in_ready(rdy[1]),
    .enc_enable(en[1]), .enc_d(d[1]), .frame_start(fs[1]), .frame_done(fd[1]),
    .underrun(ur[1]), .clr_underrun(clr[1]));

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d want %0d", nm, act, exp);
    end
  endtask

  // Expected symbols of a frame as a convolution of the payload bit stream (MSB first, zero tail).
  task automatic push_frame(input int i, input int nbytes, input int nsym);
    int nb;
    nb = 8 * nbytes;
    for (int n = 0; n < nsym; n++) begin
      logic c0;
      logic c1;
      logic uk;
      sym_t s;
      c0 = 1'b0;
      c1 = 1'b0;
      for (int k = 0; k < 4; k++) begin
        uk = 1'b0;
        if (n - k >= 0 && n - k < nb) uk = pay[(n - k) / 8][7 - ((n - k) % 8)];
        c0 = c0 ^ (g0v[3 - k] & uk);
        c1 = c1 ^ (g1v[3 - k] & uk);
      end
      s.d  = {c0, c1};
      s.st = (n == 0);
      s.dn = (n == nb + 2);
      exp_q[i].push_back(s);
    end
  endtask

  task automatic send(input int i, input logic [7:0] b);
    int n;
    n = 0;
    iv[i]   = 1'b1;
    idat[i] = b;
    while (!rdy[i] && n < 300) begin
      @(posedge clk); #1;
      n++;
    end
    if (n >= 300) chk("send_ready_timeout", rdy[i], 1);
    @(posedge clk); #1;
    iv[i] = 1'b0;
  endtask

  task automatic wait_drain(input int i, input int budget);
    int n;
    n = 0;
    while (exp_q[i].size() != 0 && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk("drain", exp_q[i].size(), 0);
    repeat (5) @(posedge clk);
    #1;
  endtask

  // Per-cycle comparison of both instances against the expected-symbol queues.
  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (!rst) begin
        chk("rst_enable", en[i], 0);
        chk("rst_enc_d", d[i], 0);
        chk("rst_in_ready", rdy[i], 1);
        chk("rst_frame_start", fs[i], 0);
        chk("rst_frame_done", fd[i], 0);
        chk("rst_underrun", ur[i], 0);
        run[i] = 0;
        low[i] = 0;
      end else if (en[i]) begin
        if (fs[i]) last_gap[i] = low[i];
        low[i] = 0;
        run[i] = run[i] + 1;
        if (exp_q[i].size() == 0) begin
          chk("unexpected_symbol_enable", en[i], 0);
        end else begin
          e = exp_q[i].pop_front();
          chk("sym_enc_d", d[i], e.d);
          chk("sym_frame_start", fs[i], e.st);
          chk("sym_frame_done", fd[i], e.dn);
        end
        if (fd[i]) chk("frame_length", run[i], 8 * fb[i] + 3);
        if (i == 1 && dec_on) begin
          if (fs[1]) hist = 3'b000;
          ub = d[1][0] ^ hist[2] ^ hist[1] ^ hist[0];
          dec_q.push_back(ub);
          hist = {ub, hist[2:1]};
        end
      end else begin
        chk("idle_enc_d", d[i], 0);
        chk("idle_frame_start", fs[i], 0);
        chk("idle_frame_done", fd[i], 0);
        low[i] = low[i] + 1;
        run[i] = 0;
      end
    end
  end

  initial begin
    int n;
    int errs;
    fb[0] = FB0;
    fb[1] = FB1;
    g0v = 4'b1101;
    g1v = 4'b1111;
    hist = 3'b000;
    dec_on = 1'b0;
    for (int i = 0; i < 2; i++) begin
      iv[i] = 1'b0; idat[i] = 8'h00; clr[i] = 1'b0;
      run[i] = 0; low[i] = 0; last_gap[i] = -1;
    end
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    for (int i = 0; i < 2; i++) begin
      chk("post_reset_in_ready", rdy[i], 1);
      chk("post_reset_enable", en[i], 0);
      chk("post_reset_underrun", ur[i], 0);
    end

    // Impulse, 1-byte frames, two in a row.
    pay.delete();
    pay.push_back(8'h80);
    push_frame(0, 1, 11);
    chk("impulse_model_s1", exp_q[0][0].d, 2'b11);
    chk("impulse_model_s2", exp_q[0][1].d, 2'b11);
    chk("impulse_model_s3", exp_q[0][2].d, 2'b01);
    chk("impulse_model_s4", exp_q[0][3].d, 2'b11);
    chk("impulse_model_s7", exp_q[0][6].d, 2'b00);
    chk("impulse_model_done11", exp_q[0][10].dn, 1);
    push_frame(0, 1, 11);
    send(0, 8'h80);
    send(0, 8'h80);
    wait_drain(0, 100);
    chk("impulse_gap", last_gap[0], 2);

    // All-zero 16-byte frame.
    pay.delete();
    for (int k = 0; k < 16; k++) pay.push_back(8'h00);
    push_frame(1, 16, 131);
    for (int k = 0; k < 16; k++) send(1, 8'h00);
    wait_drain(1, 400);
    chk("zero_underrun", ur[1], 0);

    // Back-to-back 0xA5 frames with in_valid held high.
    pay.delete();
    for (int k = 0; k < 16; k++) pay.push_back(8'hA5);
    push_frame(1, 16, 131);
    chk("a5_model_s1", exp_q[1][0].d, 2'b11);
    chk("a5_model_s2", exp_q[1][1].d, 2'b11);
    chk("a5_model_s3", exp_q[1][2].d, 2'b10);
    chk("a5_model_s4", exp_q[1][3].d, 2'b00);
    push_frame(1, 16, 131);
    for (int k = 0; k < 32; k++) send(1, 8'hA5);
    wait_drain(1, 600);
    chk("b2b_gap", last_gap[1], 2);

    // Underrun after byte 3, then synchronous clear.
    pay.delete();
    pay.push_back(8'h5A); pay.push_back(8'hC3); pay.push_back(8'h0F);
    push_frame(1, 3, 24);
    for (int k = 0; k < 3; k++) send(1, pay[k]);
    n = 0;
    while (!ur[1] && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("underrun_set", ur[1], 1);
    chk("underrun_enable_low", en[1], 0);
    chk("underrun_symbols_left", exp_q[1].size(), 0);
    @(posedge clk); #1;
    chk("underrun_sticky", ur[1], 1);
    clr[1] = 1'b1;
    @(posedge clk); #1;
    clr[1] = 1'b0;
    chk("underrun_cleared", ur[1], 0);
    repeat (6) @(posedge clk);
    #1;

    // Underrun while clr_underrun is held: set wins on the same edge.
    pay.delete();
    pay.push_back(8'h81);
    push_frame(1, 1, 8);
    clr[1] = 1'b1;
    send(1, 8'h81);
    n = 0;
    while (!ur[1] && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("set_wins_underrun", ur[1], 1);
    @(negedge clk);
    chk("clr_held_underrun", ur[1], 0);
    @(posedge clk); #1;
    clr[1] = 1'b0;
    chk("set_wins_symbols_left", exp_q[1].size(), 0);
    repeat (6) @(posedge clk);
    #1;

    // Reset asserted while tail symbol 2 is on the output, with a byte waiting in hold.
    pay.delete();
    for (int k = 0; k < 16; k++) pay.push_back(8'(k * 17 + 3));
    push_frame(1, 16, 129);
    fork
      begin
        for (int k = 0; k < 16; k++) send(1, pay[k]);
        send(1, 8'hEE);
      end
      begin
        int w;
        w = 0;
        while (!fs[1] && w < 400) begin
          @(negedge clk);
          w++;
        end
        if (w >= 400) chk("reset_test_start_timeout", fs[1], 1);
        repeat (129) @(posedge clk);
        #1;
        chk("pre_reset_in_ready", rdy[1], 0);
        rst = 1'b0;
        #1;
        chk("mid_tail_reset_enable", en[1], 0);
        chk("mid_tail_reset_in_ready", rdy[1], 1);
        chk("mid_tail_reset_enc_d", d[1], 0);
        @(posedge clk); #1;
        rst = 1'b1;
      end
    join
    chk("reset_symbols_left", exp_q[1].size(), 0);
    repeat (3) @(posedge clk);
    #1;

    // Random frames, inverted by a hard-decision decoder and compared to the payload.
    for (int f = 0; f < 3; f++) begin
      pay.delete();
      for (int k = 0; k < 16; k++) pay.push_back(8'($urandom_range(0, 255)));
      push_frame(1, 16, 131);
      dec_q.delete();
      dec_on = 1'b1;
      for (int k = 0; k < 16; k++) send(1, pay[k]);
      wait_drain(1, 400);
      dec_on = 1'b0;
      chk("loop_decoded_len", dec_q.size(), 131);
      errs = 0;
      for (int b = 0; b < 131 && b < dec_q.size(); b++) begin
        if (b < 128) begin
          if (dec_q[b] !== pay[b / 8][7 - (b % 8)]) errs++;
        end else if (dec_q[b] !== 1'b0) begin
          errs++;
        end
      end
      chk("loop_bit_errors", errs, 0);
    end

    chk("final_q0_empty", exp_q[0].size(), 0);
    chk("final_q1_empty", exp_q[1].size(), 0);
    chk("final_underrun", ur[1], 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
